// File: rtl/handshake_const_receiver_if.sv
// ---------------------------------------------------------------------------
// handshake_const_receiver_if
// Groups the two valid/ready channels around the constant-token receiver.
//   ins / ins_valid / ins_ready          : producer -> receiver token channel
//   outs / outs_match / outs_valid /
//   outs_ready                           : receiver -> consumer token channel
// Modports:
//   slave  : the receiver's view (takes ins, drives outs)
//   master : the environment's view (drives ins, takes outs)
// ---------------------------------------------------------------------------
interface handshake_const_receiver_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] ins;
   logic                  ins_valid;
   logic                  ins_ready;
   logic [DATA_WIDTH-1:0] outs;
   logic                  outs_match;
   logic                  outs_valid;
   logic                  outs_ready;

   modport slave (
      input  ins, ins_valid, outs_ready,
      output ins_ready, outs, outs_match, outs_valid
   );

   modport master (
      output ins, ins_valid, outs_ready,
      input  ins_ready, outs, outs_match, outs_valid
   );
endinterface

// File: rtl/handshake_const_receiver.sv
// ---------------------------------------------------------------------------
// handshake_const_receiver
// Two-slot elastic buffer at the receiving end of a constant-token channel.
// Every accepted token is tagged with match = (data == CONST_VALUE). The tag
// is computed once at capture and stored next to the data, so the output
// path holds no comparator. ins_ready is registered from the next state, so
// there is no combinational valid->ready path, and throughput is one token
// per cycle.
//
// Ports:
//   i_clk             clock, rising edge
//   i_rst             synchronous, active-high reset
//   bus               handshake_const_receiver_if.slave (ins/outs channels)
//   o_token_count     tokens accepted since reset (stats build only, else 0)
//   o_mismatch_count  accepted tokens != CONST_VALUE (stats build only, else 0)
//
// Optional feature macro: HANDSHAKE_RX_STATS_EN
//   defined   : saturating token / mismatch counters are built
//   undefined : counter outputs are tied to zero
// ---------------------------------------------------------------------------
module handshake_const_receiver #(
   parameter int          DATA_WIDTH  = 32,
   parameter int unsigned CONST_VALUE = 2,
   parameter int          CNT_WIDTH   = 16
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   handshake_const_receiver_if.slave bus,
   output logic [CNT_WIDTH-1:0]      o_token_count,
   output logic [CNT_WIDTH-1:0]      o_mismatch_count
);

   // Expected constant, zero-extended or truncated to the data width.
   localparam logic [DATA_WIDTH-1:0] CONST_W = DATA_WIDTH'(CONST_VALUE);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,   // no tokens
      ONE   = 2'd1,   // head only
      FULL  = 2'd2    // head + skid
   } state_t;

   state_t                r_state;
   logic [DATA_WIDTH-1:0] r_head_data;
   logic                  r_head_match;
   logic [DATA_WIDTH-1:0] r_skid_data;
   logic                  r_skid_match;
   logic                  r_outs_valid;
   logic                  r_ins_ready;

   logic w_in_xfer;
   logic w_out_xfer;
   logic w_ins_match;

   assign w_in_xfer   = bus.ins_valid & r_ins_ready;
   assign w_out_xfer  = r_outs_valid & bus.outs_ready;
   assign w_ins_match = (bus.ins == CONST_W);

   // Single FSM block; valid/ready are written alongside the state so they
   // always reflect the state being entered.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= EMPTY;
         r_head_data  <= '0;
         r_head_match <= 1'b0;
         r_skid_data  <= '0;
         r_skid_match <= 1'b0;
         r_outs_valid <= 1'b0;
         r_ins_ready  <= 1'b0;
      end else begin
         case (r_state)
            EMPTY: begin
               // ins_ready is still low on the first cycle out of reset, so
               // no transfer can be pending here; raise ready regardless.
               r_ins_ready <= 1'b1;
               if (w_in_xfer) begin
                  r_head_data  <= bus.ins;
                  r_head_match <= w_ins_match;
                  r_outs_valid <= 1'b1;
                  r_state      <= ONE;
               end
            end
            ONE: begin
               if (w_in_xfer && !w_out_xfer) begin
                  // Head is held; new token parks in the skid slot.
                  r_skid_data  <= bus.ins;
                  r_skid_match <= w_ins_match;
                  r_ins_ready  <= 1'b0;
                  r_state      <= FULL;
               end else if (!w_in_xfer && w_out_xfer) begin
                  r_outs_valid <= 1'b0;
                  r_state      <= EMPTY;
               end else if (w_in_xfer && w_out_xfer) begin
                  // Head leaves and is replaced in the same cycle.
                  r_head_data  <= bus.ins;
                  r_head_match <= w_ins_match;
               end
            end
            FULL: begin
               // ins_ready is low here, so only the output side can move.
               if (w_out_xfer) begin
                  r_head_data  <= r_skid_data;
                  r_head_match <= r_skid_match;
                  r_ins_ready  <= 1'b1;
                  r_state      <= ONE;
               end
            end
            default: begin
               // Unreachable encoding: drop everything and restart empty.
               r_state      <= EMPTY;
               r_outs_valid <= 1'b0;
               r_ins_ready  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ins_ready  = r_ins_ready;
   assign bus.outs       = r_head_data;
   assign bus.outs_match = r_head_match;
   assign bus.outs_valid = r_outs_valid;

`ifdef HANDSHAKE_RX_STATS_EN
   logic [CNT_WIDTH-1:0] r_token_count;
   logic [CNT_WIDTH-1:0] r_mismatch_count;

   // Saturating counters; they stick at all-ones instead of wrapping.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_token_count    <= '0;
         r_mismatch_count <= '0;
      end else if (w_in_xfer) begin
         if (r_token_count != '1)
            r_token_count <= r_token_count + CNT_WIDTH'(1);
         if (!w_ins_match && (r_mismatch_count != '1))
            r_mismatch_count <= r_mismatch_count + CNT_WIDTH'(1);
      end
   end

   assign o_token_count    = r_token_count;
   assign o_mismatch_count = r_mismatch_count;
`else
   assign o_token_count    = '0;
   assign o_mismatch_count = '0;
`endif

endmodule
